// File: rtl/pipeline_fifo_buffer_leveled_pkg.sv
// Shared sizing helpers for the levelled pipeline FIFO buffer.
package pipeline_fifo_buffer_leveled_pkg;

    // Ceiling log2, usable in constant expressions for port and address widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pipeline_fifo_buffer_leveled_level_tracker.sv
// Up/down occupancy counter with registered almost-full / almost-empty thresholds.
module pipeline_fifo_buffer_leveled_level_tracker
    import pipeline_fifo_buffer_leveled_pkg::*;
#(
    parameter int DEPTH              = 17,
    parameter int ALMOST_FULL_LEVEL  = DEPTH,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                        clock,
    input  logic                        clear_n,
    input  logic                        flush,
    input  logic                        inc,
    input  logic                        dec,
    output logic [clog2(DEPTH+2)-1:0]   count,
    output logic                        almost_full,
    output logic                        almost_empty
);

    localparam int COUNT_WIDTH = clog2(DEPTH + 2);
    localparam logic [COUNT_WIDTH-1:0] AF_LEVEL = COUNT_WIDTH'(ALMOST_FULL_LEVEL);
    localparam logic [COUNT_WIDTH-1:0] AE_LEVEL = COUNT_WIDTH'(ALMOST_EMPTY_LEVEL);
    localparam logic                   AF_IDLE  = (ALMOST_FULL_LEVEL == 0);

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   almost_full_q, almost_full_d;
    logic                   almost_empty_q, almost_empty_d;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (inc && !dec) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (dec && !inc) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    // Flags follow the next count so they change on the same edge as count.
    assign almost_full_d  = (count_d >= AF_LEVEL);
    assign almost_empty_d = (count_d <= AE_LEVEL);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_q        <= '0;
            almost_full_q  <= AF_IDLE;
            almost_empty_q <= 1'b1;
        end else begin
            count_q        <= count_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign count        = count_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;

endmodule

// File: rtl/pipeline_fifo_buffer_leveled.sv
// Ready/valid FIFO: dual-port RAM plus registered output word, with occupancy
// count, programmable almost-full/almost-empty flags and synchronous flush.
module pipeline_fifo_buffer_leveled
    import pipeline_fifo_buffer_leveled_pkg::*;
#(
    parameter int WORD_WIDTH         = 33,
    parameter int DEPTH              = 17,
    parameter     RAMSTYLE           = "block",
    parameter int ALMOST_FULL_LEVEL  = DEPTH,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                        clock,
    input  logic                        clear_n,
    input  logic                        flush,
    input  logic                        input_valid,
    output logic                        input_ready,
    input  logic [WORD_WIDTH-1:0]       input_data,
    output logic                        output_valid,
    input  logic                        output_ready,
    output logic [WORD_WIDTH-1:0]       output_data,
    output logic [clog2(DEPTH+2)-1:0]   stored_count,
    output logic                        almost_full,
    output logic                        almost_empty
);

    localparam int ADDR_WIDTH = clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (DEPTH < 2 || ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH + 1 ||
        ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH ||
        RAMSTYLE == "") begin : g_bad_params
        $error("pipeline_fifo_buffer_leveled: illegal parameter combination");
    end

    (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic                  wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] out_data_q;

    logic addr_eq, ram_empty, ram_full;
    logic insert, out_hs, out_slot, load;

    // Wrap bits distinguish full from empty when the addresses coincide.
    assign addr_eq   = (wr_addr_q == rd_addr_q);
    assign ram_empty = addr_eq && (wr_wrap_q == rd_wrap_q);
    assign ram_full  = addr_eq && (wr_wrap_q != rd_wrap_q);

    assign input_ready = !ram_full && !flush;
    assign insert      = input_valid && input_ready;
    assign out_hs      = out_valid_q && output_ready;
    assign out_slot    = out_hs || !out_valid_q;
    assign load        = out_slot && !ram_empty && !flush;

    always_comb begin
        wr_addr_d   = wr_addr_q;
        wr_wrap_d   = wr_wrap_q;
        rd_addr_d   = rd_addr_q;
        rd_wrap_d   = rd_wrap_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            wr_addr_d   = '0;
            wr_wrap_d   = 1'b0;
            rd_addr_d   = '0;
            rd_wrap_d   = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (insert) begin
                if (wr_addr_q == LAST_ADDR) begin
                    wr_addr_d = '0;
                    wr_wrap_d = !wr_wrap_q;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                end
            end
            if (load) begin
                if (rd_addr_q == LAST_ADDR) begin
                    rd_addr_d = '0;
                    rd_wrap_d = !rd_wrap_q;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
            end
            if (out_slot) begin
                out_valid_d = !ram_empty;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_addr_q   <= '0;
            wr_wrap_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_wrap_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            wr_wrap_q   <= wr_wrap_d;
            rd_addr_q   <= rd_addr_d;
            rd_wrap_q   <= rd_wrap_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Read and write addresses only coincide when empty (no read) or full
    // (no write), so no forwarding path is required.
    always_ff @(posedge clock) begin
        if (insert) begin
            mem[wr_addr_q] <= input_data;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            out_data_q <= '0;
        end else if (load) begin
            out_data_q <= mem[rd_addr_q];
        end
    end

    assign output_valid = out_valid_q;
    assign output_data  = out_data_q;

    pipeline_fifo_buffer_leveled_level_tracker #(
        .DEPTH              (DEPTH),
        .ALMOST_FULL_LEVEL  (ALMOST_FULL_LEVEL),
        .ALMOST_EMPTY_LEVEL (ALMOST_EMPTY_LEVEL)
    ) u_level (
        .clock        (clock),
        .clear_n      (clear_n),
        .flush        (flush),
        .inc          (insert),
        .dec          (out_hs),
        .count        (stored_count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

endmodule

// File: tb/tb_pipeline_fifo_buffer_leveled.sv
// Scoreboard bench for pipeline_fifo_buffer_leveled with DEPTH=4, 8-bit words.
module tb_pipeline_fifo_buffer_leveled;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int CW = $clog2(D + 2);

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          flush = 1'b0;
    logic          input_valid = 1'b0;
    logic          output_ready = 1'b0;
    logic [W-1:0]  input_data = '0;
    logic          input_ready, output_valid, almost_full, almost_empty;
    logic [W-1:0]  output_data;
    logic [CW-1:0] stored_count;

    int           checks = 0;
    int           errors = 0;
    int           n_out = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    pipeline_fifo_buffer_leveled #(
        .WORD_WIDTH         (W),
        .DEPTH              (D),
        .RAMSTYLE           ("block"),
        .ALMOST_FULL_LEVEL  (AF),
        .ALMOST_EMPTY_LEVEL (AE)
    ) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .flush        (flush),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .stored_count (stored_count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every completed output handshake is compared with the oldest expected word.
    always @(negedge clock) begin
        if (clear_n && output_valid && output_ready) begin
            checks++;
            n_out++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h, no word expected", output_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (output_data !== exp_w) begin
                    errors++;
                    $display("FAIL output_data: got %0h, expected %0h", output_data, exp_w);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        input_valid = 1'b1;
        input_data  = d;
        @(negedge clock);
        check("write_ready", input_ready, 1);
        if (input_ready) exp_q.push_back(d);
        step();
        input_valid = 1'b0;
    endtask

    initial begin
        int n_acc;

        // Reset then idle
        #12 clear_n = 1'b1;
        step();
        check("rst_input_ready", input_ready, 1);
        check("rst_output_valid", output_valid, 0);
        check("rst_count", stored_count, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_almost_full", almost_full, 0);

        // Fill with the consumer stalled: only five words fit
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            input_valid = 1'b1;
            input_data  = 8'(8'h10 + i);
            @(negedge clock);
            check("fill_count", stored_count, (i < 5) ? i : 5);
            check("fill_af", almost_full, (i >= 4) ? 1 : 0);
            check("fill_ae", almost_empty, (i <= 1) ? 1 : 0);
            check("fill_ready", input_ready, (i < 5) ? 1 : 0);
            if (input_ready) begin
                exp_q.push_back(input_data);
                n_acc++;
            end
            step();
        end
        input_valid = 1'b0;
        @(negedge clock);
        check("fill_accepted", n_acc, 5);
        check("full_ready", input_ready, 0);
        check("full_count", stored_count, 5);
        check("full_af", almost_full, 1);
        check("full_valid", output_valid, 1);
        check("full_head", output_data, 8'h10);
        step();

        // Drain from full
        output_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            check("drain_count", stored_count, 5 - j);
            check("drain_ready", input_ready, (j >= 1) ? 1 : 0);
            check("drain_ae", almost_empty, ((5 - j) <= 1) ? 1 : 0);
            check("drain_af", almost_full, ((5 - j) >= 4) ? 1 : 0);
            check("drain_valid", output_valid, (j < 5) ? 1 : 0);
            step();
        end

        // Streaming: 20 words, both sides always ready, five address wraps
        for (int i = 0; i < 22; i++) begin
            input_valid = (i < 20);
            input_data  = 8'(8'h40 + i);
            @(negedge clock);
            if (i < 20) begin
                check("stream_ready", input_ready, 1);
                exp_q.push_back(input_data);
            end
            check("stream_count", stored_count, (i == 0) ? 0 : (i == 1) ? 1 : (i <= 20) ? 2 : 1);
            check("stream_valid", output_valid, (i >= 2) ? 1 : 0);
            step();
        end
        input_valid = 1'b0;
        @(negedge clock);
        check("stream_end_count", stored_count, 0);
        check("stream_end_valid", output_valid, 0);
        step();

        // Flush with three words held and a word offered
        output_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(8'(8'hA0 + i));
        input_valid = 1'b1;
        input_data  = 8'h55;
        flush       = 1'b1;
        @(negedge clock);
        check("preflush_count", stored_count, 3);
        check("flush_ready", input_ready, 0);
        step();
        flush       = 1'b0;
        input_valid = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("flush_valid", output_valid, 0);
        check("flush_count", stored_count, 0);
        check("flush_ae", almost_empty, 1);
        check("flush_af", almost_full, 0);
        step();
        output_ready = 1'b1;
        write_word(8'hAA);
        @(negedge clock);
        check("post_flush_lat1_valid", output_valid, 0);
        check("post_flush_lat1_count", stored_count, 1);
        step();
        @(negedge clock);
        check("post_flush_lat2_valid", output_valid, 1);
        check("post_flush_lat2_data", output_data, 8'hAA);
        step();

        // Asynchronous reset in the middle of operation
        output_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(8'(8'hB0 + i));
        @(negedge clock);
        check("prereset_count", stored_count, 4);
        check("prereset_af", almost_full, 1);
        #2 clear_n = 1'b0;
        #1;
        check("arst_input_ready", input_ready, 1);
        check("arst_output_valid", output_valid, 0);
        check("arst_count", stored_count, 0);
        check("arst_almost_empty", almost_empty, 1);
        check("arst_almost_full", almost_full, 0);
        check("arst_output_data", output_data, 0);
        exp_q.delete();
        #1 clear_n = 1'b1;
        step();
        output_ready = 1'b1;
        write_word(8'hC0);
        for (int k = 0; k < 5; k++) step();

        @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        check("outputs_seen", n_out, 27);
        check("final_count", stored_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_fifo_buffer_leveled.md
# pipeline_fifo_buffer_leveled

Parametrised successor to the pipeline FIFO buffer. It decouples a ready/valid producer from a ready/valid consumer through a synchronous dual-port RAM plus a registered output stage, and adds three things:
- a registered occupancy count;
- programmable almost-full and almost-empty flags for upstream throttling and downstream batching;
- a synchronous flush.

It sits between pipeline stages wherever rate smoothing, deadlock-avoidance depth, or early back-pressure is needed.

## Interface
Parameters:
- WORD_WIDTH, 33, data word width.
- DEPTH, 17, RAM entries; any integer ≥ 2, not only powers of 2.
- RAMSTYLE, "block", passed to the RAM.
- ALMOST_FULL_LEVEL, DEPTH, occupancy at or above which almost_full asserts; legal 1..DEPTH+1.
- ALMOST_EMPTY_LEVEL, 1, occupancy at or below which almost_empty asserts; legal 0..DEPTH.

Ports:
- clock  in  1  single clock, rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all stored words.
- input_valid  in  1  producer has a word.
- input_ready  out  1  buffer can accept a word.
- input_data  in  WORD_WIDTH  producer word.
- output_valid  out  1  output_data holds a word.
- output_ready  in  1  consumer accepts the word.
- output_data  out  WORD_WIDTH  registered RAM read data.
- stored_count  out  clog2(DEPTH+2)  words held in RAM plus output register, range 0..DEPTH+1.
- almost_full  out  1  registered; stored_count ≥ ALMOST_FULL_LEVEL.
- almost_empty  out  1  registered; stored_count ≤ ALMOST_EMPTY_LEVEL.

## Operation
- Storage: RAM of DEPTH words plus one output register, for a total capacity of DEPTH+1.
- Addressing: read and write address counters, each with a wrap-around bit, wrap from DEPTH-1 to 0 and toggle their bit on wrap.
  - Empty: addresses equal and wrap bits equal.
  - Full: addresses equal and wrap bits differ.
- Insert when input_valid && input_ready. input_ready = !ram_full && !flush.
- Load output register (RAM read, read address increment) when ram not empty && (output handshake || !output_valid).
  - output_valid is set to !ram_empty when loaded, held otherwise.
- Count and flags:
  - stored_count +1 on insert only, -1 on output handshake only, unchanged on both or neither.
  - almost_full and almost_empty are computed from next_count, so they align with stored_count.
- Flush (synchronous, one cycle, highest priority after reset):
  - Addresses, wrap bits, output_valid and stored_count go to 0.
  - almost_empty goes to 1; almost_full goes to (ALMOST_FULL_LEVEL == 0), which is always 0 for legal values.
  - input_ready is low during flush, so no word enters.
  - An output handshake in the flush cycle is a completed transfer.
- Reset: on clear_n low, all state is cleared asynchronously to the flush values. RAM contents are not cleared and are don't-care.
- Reset values: input_ready 1, output_valid 0, stored_count 0, almost_full 0, almost_empty 1, output_data don't-care (0 in simulation).
- Illegal parameters: elaboration-time error via a generate-block check.

## Timing
- Input-to-output latency is 2 cycles into an empty buffer (RAM write, then RAM read into the output register).
- Throughput is 1 word/cycle sustained in both directions.
- No combinational path from output_ready to input_ready, or from input_valid to output_valid.
- input_ready depends on state registers and flush only.
- At full, a concurrent output handshake does not raise input_ready in the same cycle; it rises the next cycle.
- Concurrent read/write never touches the same RAM address, so no write-forwarding logic is needed.
- stored_count and both flags update on the clock edge that completes the handshake.

## Structure
- Shared header pipeline_fifo_defs.vh holds:
  - the clog2 function;
  - ADDR_WIDTH = clog2(DEPTH);
  - COUNT_WIDTH = clog2(DEPTH+2).
- Reused existing blocks: RAM_Simple_Dual_Port, Counter_Binary (×2) and Register_Toggle (×2).
- New sub-module fifo_level_tracker contains:
  - the up/down occupancy counter;
  - the registered threshold compare;
  - the flush/reset handling.

## Test plan
- Reset then idle (DEPTH=4, WORD_WIDTH=8, ALMOST_FULL_LEVEL=4, ALMOST_EMPTY_LEVEL=1): assert and release clear_n -> input_ready=1, output_valid=0, stored_count=0, almost_empty=1, almost_full=0.
- Fill with output_ready=0: write 0x10..0x15 back-to-back -> 5 words accepted; input_ready=0 after the 5th; stored_count=5; almost_full=1 from count 4; output_data=0x10.
- Drain and order: from full, set output_ready=1 -> outputs 0x10..0x14 on consecutive cycles; input_ready=1 one cycle after the first handshake; count reaches 0; almost_empty=1 when count ≤ 1.
- Streaming with wrap-around: 20 words with both sides always ready -> first output 2 cycles after the first input; 1 word/cycle; data in order across ≥ 4 address wraps; count stays 1–2.
- Flush with count 3 and input_valid=1 -> that input is not accepted; next cycle output_valid=0 and count=0; a following write of 0xAA appears 2 cycles later.
- Mid-operation reset: pulse clear_n low asynchronously (between edges) with count 4 -> outputs go to reset values immediately; normal operation resumes after release.
